// File: rtl/arb2_8bit_if.sv
// arb2_8bit_if: request/data/ack lines of the two producers plus the Y valid/ready output channel.
interface arb2_8bit_if;
  localparam int unsigned DW = 8;

  logic          Req0;
  logic [DW-1:0] D0;
  logic          Req1;
  logic [DW-1:0] D1;
  logic          Ack0;
  logic          Ack1;
  logic          S;
  logic [DW-1:0] Y;
  logic          Yvalid;
  logic          Yready;

  modport slave (
    input  Req0, D0, Req1, D1, Yready,
    output Ack0, Ack1, S, Y, Yvalid
  );

  modport master (
    output Req0, D0, Req1, D1, Yready,
    input  Ack0, Ack1, S, Y, Yvalid
  );
endinterface

// File: rtl/arb2_8bit.sv
// arb2_8bit: two-requester byte arbiter with registered mux select and Y/Yvalid/Yready output.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module arb2_8bit (
  input  logic       Clk,
  input  logic       Reset,
  arb2_8bit_if.slave bus
);
  localparam int unsigned DW = 8;

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t        state, state_n;
  logic [DW-1:0] y_q, y_n;
  logic          s_q, s_n;
  logic          ack0_q, ack0_n;
  logic          ack1_q, ack1_n;
  logic          cap, elig0, elig1, win1;
`ifndef ARB_FIXED_PRIO_EN
  logic          last_q, last_n;
`endif

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      y_q    <= DW'(0);
      s_q    <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_q <= 1'b1;
`endif
    end else begin
      state  <= state_n;
      y_q    <= y_n;
      s_q    <= s_n;
      ack0_q <= ack0_n;
      ack1_q <= ack1_n;
`ifndef ARB_FIXED_PRIO_EN
      last_q <= last_n;
`endif
    end
  end

  // Arbitration and next-state; a requester being acked this cycle cannot win again
  always_comb begin
    state_n = state;
    y_n     = y_q;
    s_n     = s_q;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    last_n  = last_q;
`endif
    cap   = (state == IDLE) || bus.Yready;
    elig0 = bus.Req0 && !ack0_q;
    elig1 = bus.Req1 && !ack1_q;
`ifdef ARB_FIXED_PRIO_EN
    win1  = elig1 && !elig0;
`else
    win1  = elig1 && (!elig0 || !last_q);
`endif
    if (cap) begin
      if (elig0 || elig1) begin
        state_n = FULL;
        y_n     = win1 ? bus.D1 : bus.D0;
        s_n     = win1;
        ack0_n  = !win1;
        ack1_n  = win1;
`ifndef ARB_FIXED_PRIO_EN
        last_n  = win1;
`endif
      end else begin
        state_n = IDLE;
      end
    end
  end

  assign bus.Y      = y_q;
  assign bus.S      = s_q;
  assign bus.Ack0   = ack0_q;
  assign bus.Ack1   = ack1_q;
  assign bus.Yvalid = (state == FULL);
endmodule

// File: tb/tb_arb2_8bit.sv
// tb_arb2_8bit: directed bench for arb2_8bit with a capture scoreboard popped on every Ack pulse.
module tb_arb2_8bit;
  logic clk = 1'b0;
  logic rst;

  arb2_8bit_if bus ();

  arb2_8bit dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       s;
    logic [7:0] y;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later; each Ack must match the oldest expected capture
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.Ack0 || bus.Ack1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, bus.Ack1, bus.Ack0}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_y", 32'(bus.Y), 32'(e.y));
        chk("sb_s", 32'(bus.S), 32'(e.s));
        chk("sb_ack", {30'd0, bus.Ack1, bus.Ack0}, e.s ? 32'd2 : 32'd1);
        chk("sb_yvalid", 32'(bus.Yvalid), 32'd1);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n0, n1, acks;
    logic prev_ack0;
    rst        = 1'b1;
    bus.Req0   = 1'b0;
    bus.Req1   = 1'b0;
    bus.D0     = 8'h00;
    bus.D1     = 8'h00;
    bus.Yready = 1'b0;

    // Reset values
    do_reset();
    chk("rst_y", 32'(bus.Y), 32'h00);
    chk("rst_yvalid", 32'(bus.Yvalid), 32'd0);
    chk("rst_s", 32'(bus.S), 32'd0);
    chk("rst_ack", {30'd0, bus.Ack1, bus.Ack0}, 32'd0);

    // Single capture of A5 then drain
    bus.Req0 = 1'b1; bus.D0 = 8'hA5; bus.Yready = 1'b1;
    sb.push_back('{s: 1'b0, y: 8'hA5});
    tick();
    chk("t1_y", 32'(bus.Y), 32'hA5);
    chk("t1_ack0", 32'(bus.Ack0), 32'd1);
    bus.Req0 = 1'b0;
    tick();
    chk("t1_drain_yvalid", 32'(bus.Yvalid), 32'd0);
    chk("t1_drain_ack0", 32'(bus.Ack0), 32'd0);
    chk("t1_hold_y", 32'(bus.Y), 32'hA5);

    // Both requesters streaming: 10,20,11,21,...
    do_reset();
    bus.Yready = 1'b1;
    bus.Req0 = 1'b1; bus.D0 = 8'h10;
    bus.Req1 = 1'b1; bus.D1 = 8'h20;
    for (int n = 0; n < 4; n++) begin
      sb.push_back('{s: 1'b0, y: 8'(8'h10 + n)});
      sb.push_back('{s: 1'b1, y: 8'(8'h20 + n)});
    end
    n0 = 0; n1 = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.Ack0) begin
        n0++;
        if (n0 < 4) bus.D0 = 8'(8'h10 + n0); else bus.Req0 = 1'b0;
      end
      if (bus.Ack1) begin
        n1++;
        if (n1 < 4) bus.D1 = 8'(8'h20 + n1); else bus.Req1 = 1'b0;
      end
    end
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);
    tick();
    chk("t2_idle_yvalid", 32'(bus.Yvalid), 32'd0);

    // Stall with Yready=0: 3C holds, Req0 waits
    bus.Yready = 1'b0;
    bus.Req1 = 1'b1; bus.D1 = 8'h3C;
    sb.push_back('{s: 1'b1, y: 8'h3C});
    tick();
    bus.Req1 = 1'b0;
    bus.Req0 = 1'b1; bus.D0 = 8'h77;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t3_hold_y", 32'(bus.Y), 32'h3C);
      chk("t3_hold_yvalid", 32'(bus.Yvalid), 32'd1);
      chk("t3_hold_s", 32'(bus.S), 32'd1);
    end
    sb.push_back('{s: 1'b0, y: 8'h77});
    bus.Yready = 1'b1;
    tick();
    chk("t3_release_y", 32'(bus.Y), 32'h77);
    bus.Req0 = 1'b0;
    tick();
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Single requester held: one byte every second edge
    bus.Req0 = 1'b1; bus.D0 = 8'h5A;
    for (int n = 0; n < 3; n++) sb.push_back('{s: 1'b0, y: 8'h5A});
    acks = 0; prev_ack0 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t4_ack0_consec", 32'(prev_ack0 && bus.Ack0), 32'd0);
      if (bus.Ack0) acks++;
      prev_ack0 = bus.Ack0;
    end
    bus.Req0 = 1'b0;
    chk("t4_ack_count", 32'(acks), 32'd3);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-transfer with requests present; first tie afterwards goes to requester 0
    bus.Yready = 1'b0;
    bus.Req1 = 1'b1; bus.D1 = 8'hC3;
    sb.push_back('{s: 1'b1, y: 8'hC3});
    tick();
    bus.Req1 = 1'b0;
    tick();
    chk("t5_pre_yvalid", 32'(bus.Yvalid), 32'd1);
    rst = 1'b1;
    bus.Req0 = 1'b1; bus.D0 = 8'h11;
    bus.Req1 = 1'b1; bus.D1 = 8'h22;
    tick();
    chk("t5_rst_yvalid", 32'(bus.Yvalid), 32'd0);
    chk("t5_rst_y", 32'(bus.Y), 32'h00);
    chk("t5_rst_s", 32'(bus.S), 32'd0);
    chk("t5_rst_ack", {30'd0, bus.Ack1, bus.Ack0}, 32'd0);
    rst = 1'b0;
    bus.Yready = 1'b1;
    sb.push_back('{s: 1'b0, y: 8'h11});
    tick();
    bus.Req0 = 1'b0;
    sb.push_back('{s: 1'b1, y: 8'h22});
    tick();
    bus.Req1 = 1'b0;
    tick();
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // Idle with Yready=1 and no requests
    do_reset();
    bus.Yready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t6_idle_yvalid", 32'(bus.Yvalid), 32'd0);
      chk("t6_idle_ack", {30'd0, bus.Ack1, bus.Ack0}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arb2_8bit.md
# arb2_8bit

Two-requester 8-bit arbiter and output register for the shared byte path built around the 2:1 8-bit mux. Two producers each present a byte plus a request. The block picks one winner per transfer, drives the mux select, and captures the selected byte into a registered output with a valid/ready handshake. Each winner gets a one-cycle acknowledge.

## Interface
- No parameters; data width fixed at 8.
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req0  input  1  requester 0 has a byte on D0.
- D0  input  8  requester 0 data; must be stable while Req0=1.
- Req1  input  1  requester 1 has a byte on D1.
- D1  input  8  requester 1 data; must be stable while Req1=1.
- Ack0  output  1  one-cycle pulse: D0 was captured at the previous edge.
- Ack1  output  1  one-cycle pulse: D1 was captured at the previous edge.
- S  output  1  registered mux select of the last capture (0 = D0, 1 = D1).
- Y  output  8  registered output byte.
- Yvalid  output  1  Y holds an unconsumed byte.
- Yready  input  1  consumer accepts Y on any edge where Yvalid=1 and Yready=1.

## Operation
- Clocking and reset: one clock (Clk). Reset is synchronous and active-high.
- States:
  - IDLE: Yvalid=0.
  - FULL: Yvalid=1.
- Capture opportunity: an edge where the state is IDLE, or where the state is FULL and Yready=1. At such an edge:
  - Eligible requesters: ReqN=1 and AckN=0 in that cycle. A requester that is being acknowledged cannot win again in the same cycle.
  - No eligible requester: go to IDLE. Yvalid goes 0, or stays 0. Y holds its value.
  - One eligible requester: it wins.
  - Both eligible: the one not served last wins (round-robin pointer `last`).
  - On a win: Y<=D(winner), S<=winner, last<=winner, Ack(winner)<=1, state<=FULL.
- FULL with Yready=0: Y, S and Yvalid hold. Requests wait and are never dropped.
- AckN is high for exactly one cycle per captured byte. Ack0 and Ack1 are never high together.
- Requester protocol: hold ReqN/DN until AckN is seen. Then deassert, or present the next byte, on the following edge.
- Yready while Yvalid=0: ignored.

## Timing
- Reset values: Y=8'h00, Yvalid=0, Ack0=0, Ack1=0, S=0, last=1 (requester 0 wins the first tie), state IDLE.
- Latency:
  - Req sampled at edge k in IDLE gives Y/Yvalid/Ack at edge k (visible in cycle k+1).
  - The consumer can take the byte at edge k+1 at the earliest.
- Throughput: back-to-back, one byte per cycle when Yready=1 continuously and requests alternate.
- A single requester holding Req high through its Ack gets at most one byte every 2 cycles.
- Reset asserted mid-transfer: the byte in Y is discarded. No Ack is issued at that edge. All outputs take their reset values at that edge.
- Simultaneous Reset and Req: Reset wins.

## Configuration
- ARB_FIXED_PRIO_EN defined:
  - Requester 0 always wins ties; `last` is not used.
  - Requester 1 can starve; this is acceptable for debug/priority builds.
- ARB_FIXED_PRIO_EN undefined (default): round-robin as above.

## Test plan
- Reset, then Req0=1, D0=8'hA5, Yready=1 -> Y=8'hA5, Yvalid=1, S=0 after the first edge. Ack0 pulses for 1 cycle. Yvalid=0 after the next edge once Req0 is dropped.
- Both Req held with fresh data each Ack (D0=8'h10+n, D1=8'h20+n), Yready=1 -> Y sequence 10,20,11,21,...; S alternates 0,1,0,1. Under ARB_FIXED_PRIO_EN -> Y=10,20,11,... with Req1 served only in cycles where Req0 is ineligible (its Ack is high).
- Req1=1, D1=8'h3C, Yready=0 for 5 cycles -> Y=8'h3C and Yvalid=1 hold for all 5 cycles. Ack1 pulses once only. Req0 raised meanwhile is not captured until Yready=1.
- Req0=1 held continuously with Yready=1 -> captures on every 2nd edge. Ack0 never high in two consecutive cycles.
- Reset asserted while Yvalid=1, Yready=0 -> next edge gives Yvalid=0, Y=8'h00, S=0, no Ack. The first tie after reset goes to requester 0.
- Yready=1 with no requests for 10 cycles after reset -> Yvalid stays 0 and Ack0/Ack1 stay 0.
